// File: rtl/frv_rvfi_emitter_if.sv
// Retirement-record, load-response and RVFI trace signals of the emitter.
// master = producer side (writeback + memory + trace sink), slave = emitter.
interface frv_rvfi_emitter_if #(
  parameter int XLEN = 32
);
  logic                ret_valid;
  logic                ret_ready;
  logic [2*XLEN-1:0]   ret_pc;
  logic [31:0]         ret_insn;
  logic                ret_trap;
  logic [14:0]         ret_rs_addr;
  logic [3*XLEN-1:0]   ret_rs_rdata;
  logic [4:0]          ret_rd_addr;
  logic                ret_rd_wide;
  logic [2*XLEN-1:0]   ret_rd_wdata;
  logic [XLEN-1:0]     ret_mem_addr;
  logic [7:0]          ret_mem_mask;
  logic [XLEN-1:0]     ret_mem_wdata;

  logic                mem_rsp_valid;
  logic [XLEN-1:0]     mem_rsp_rdata;
  logic                mem_rsp_error;

  logic                rvfi_valid;
  logic [63:0]         rvfi_order;
  logic [31:0]         rvfi_insn;
  logic                rvfi_trap;
  logic                rvfi_intr;
  logic [2*XLEN-1:0]   rvfi_pc;
  logic [14:0]         rvfi_rs_addr;
  logic [3*XLEN-1:0]   rvfi_rs_rdata;
  logic [4:0]          rvfi_rd_addr;
  logic                rvfi_rd_wide;
  logic [2*XLEN-1:0]   rvfi_rd_wdata;
  logic [XLEN-1:0]     rvfi_mem_addr;
  logic [7:0]          rvfi_mem_mask;
  logic [XLEN-1:0]     rvfi_mem_wdata;
  logic [XLEN-1:0]     rvfi_mem_rdata;

  modport master (
    output ret_valid, ret_pc, ret_insn, ret_trap, ret_rs_addr, ret_rs_rdata,
           ret_rd_addr, ret_rd_wide, ret_rd_wdata, ret_mem_addr, ret_mem_mask,
           ret_mem_wdata, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error,
    input  ret_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr,
           rvfi_pc, rvfi_rs_addr, rvfi_rs_rdata, rvfi_rd_addr, rvfi_rd_wide,
           rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_mask, rvfi_mem_wdata,
           rvfi_mem_rdata
  );

  modport slave (
    input  ret_valid, ret_pc, ret_insn, ret_trap, ret_rs_addr, ret_rs_rdata,
           ret_rd_addr, ret_rd_wide, ret_rd_wdata, ret_mem_addr, ret_mem_mask,
           ret_mem_wdata, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error,
    output ret_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr,
           rvfi_pc, rvfi_rs_addr, rvfi_rs_rdata, rvfi_rd_addr, rvfi_rd_wide,
           rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_mask, rvfi_mem_wdata,
           rvfi_mem_rdata
  );
endinterface

// File: rtl/frv_rvfi_emitter.sv
// RVFI trace emitter: registers one retirement record per handshake, holding
// loads until their data returns, with a monotonic order counter.
module frv_rvfi_emitter #(
  parameter int          XLEN       = 32,
  parameter logic [63:0] ORDER_INIT = 64'd0
) (
  input logic               g_clk,
  input logic               g_resetn,
  frv_rvfi_emitter_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT_MEM = 1'b1} state_t;

  state_t state_reg, state_next;
  logic   is_load, load_take, emit, from_mem;

  logic [63:0] count_reg;
  logic        intr_pending_reg;

  logic [2*XLEN-1:0] hold_pc_reg;
  logic [31:0]       hold_insn_reg;
  logic [14:0]       hold_rs_addr_reg;
  logic [3*XLEN-1:0] hold_rs_rdata_reg;
  logic [4:0]        hold_rd_addr_reg;
  logic              hold_rd_wide_reg;
  logic [XLEN-1:0]   hold_rd_hi_reg;
  logic [XLEN-1:0]   hold_mem_addr_reg;
  logic [7:0]        hold_mem_mask_reg;
  logic [XLEN-1:0]   hold_mem_wdata_reg;

  logic [2*XLEN-1:0] src_pc;
  logic [31:0]       src_insn;
  logic [14:0]       src_rs_addr;
  logic [3*XLEN-1:0] src_rs_rdata;
  logic [4:0]        src_rd_addr;
  logic              src_rd_wide;
  logic [XLEN-1:0]   src_rd_hi;
  logic [XLEN-1:0]   src_mem_addr;
  logic [7:0]        src_mem_mask;
  logic [XLEN-1:0]   src_mem_wdata;

  logic              emit_trap;
  logic [XLEN-1:0]   emit_lo, emit_hi, emit_mem_rdata;
  logic [4:0]        emit_rd_addr;
  logic [2*XLEN-1:0] emit_rd_wdata;
  logic [7:0]        emit_mem_mask;

  // A trapped record never waits for memory, whatever its rmask says.
  assign is_load = (bus.ret_mem_mask[3:0] != 4'd0) && !bus.ret_trap;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (bus.ret_valid && is_load) state_next = ST_WAIT_MEM;
      ST_WAIT_MEM: if (bus.mem_rsp_valid)        state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ret_ready = 1'b0;
    load_take     = 1'b0;
    emit          = 1'b0;
    from_mem      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.ret_ready = 1'b1;
        load_take     = bus.ret_valid && is_load;
        emit          = bus.ret_valid && !is_load;
      end
      ST_WAIT_MEM: begin
        from_mem = 1'b1;
        emit     = bus.mem_rsp_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      hold_pc_reg        <= '0;
      hold_insn_reg      <= '0;
      hold_rs_addr_reg   <= '0;
      hold_rs_rdata_reg  <= '0;
      hold_rd_addr_reg   <= '0;
      hold_rd_wide_reg   <= 1'b0;
      hold_rd_hi_reg     <= '0;
      hold_mem_addr_reg  <= '0;
      hold_mem_mask_reg  <= '0;
      hold_mem_wdata_reg <= '0;
    end else if (load_take) begin
      hold_pc_reg        <= bus.ret_pc;
      hold_insn_reg      <= bus.ret_insn;
      hold_rs_addr_reg   <= bus.ret_rs_addr;
      hold_rs_rdata_reg  <= bus.ret_rs_rdata;
      hold_rd_addr_reg   <= bus.ret_rd_addr;
      hold_rd_wide_reg   <= bus.ret_rd_wide;
      hold_rd_hi_reg     <= bus.ret_rd_wdata[2*XLEN-1:XLEN];
      hold_mem_addr_reg  <= bus.ret_mem_addr;
      hold_mem_mask_reg  <= bus.ret_mem_mask;
      hold_mem_wdata_reg <= bus.ret_mem_wdata;
    end
  end

  assign src_pc        = from_mem ? hold_pc_reg        : bus.ret_pc;
  assign src_insn      = from_mem ? hold_insn_reg      : bus.ret_insn;
  assign src_rs_addr   = from_mem ? hold_rs_addr_reg   : bus.ret_rs_addr;
  assign src_rs_rdata  = from_mem ? hold_rs_rdata_reg  : bus.ret_rs_rdata;
  assign src_rd_addr   = from_mem ? hold_rd_addr_reg   : bus.ret_rd_addr;
  assign src_rd_wide   = from_mem ? hold_rd_wide_reg   : bus.ret_rd_wide;
  assign src_rd_hi     = from_mem ? hold_rd_hi_reg     : bus.ret_rd_wdata[2*XLEN-1:XLEN];
  assign src_mem_addr  = from_mem ? hold_mem_addr_reg  : bus.ret_mem_addr;
  assign src_mem_mask  = from_mem ? hold_mem_mask_reg  : bus.ret_mem_mask;
  assign src_mem_wdata = from_mem ? hold_mem_wdata_reg : bus.ret_mem_wdata;

  // A bus error turns the held load into a trap with no architectural effect.
  assign emit_trap      = from_mem ? bus.mem_rsp_error : bus.ret_trap;
  assign emit_lo        = from_mem ? bus.mem_rsp_rdata : bus.ret_rd_wdata[XLEN-1:0];
  assign emit_hi        = src_rd_wide ? src_rd_hi : '0;
  assign emit_rd_addr   = emit_trap ? 5'd0 : src_rd_addr;
  assign emit_rd_wdata  = (emit_rd_addr == 5'd0) ? '0 : {emit_hi, emit_lo};
  assign emit_mem_mask  = emit_trap ? 8'd0 : src_mem_mask;
  assign emit_mem_rdata = from_mem ? bus.mem_rsp_rdata : '0;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      bus.rvfi_valid     <= 1'b0;
      bus.rvfi_order     <= '0;
      bus.rvfi_insn      <= '0;
      bus.rvfi_trap      <= 1'b0;
      bus.rvfi_intr      <= 1'b0;
      bus.rvfi_pc        <= '0;
      bus.rvfi_rs_addr   <= '0;
      bus.rvfi_rs_rdata  <= '0;
      bus.rvfi_rd_addr   <= '0;
      bus.rvfi_rd_wide   <= 1'b0;
      bus.rvfi_rd_wdata  <= '0;
      bus.rvfi_mem_addr  <= '0;
      bus.rvfi_mem_mask  <= '0;
      bus.rvfi_mem_wdata <= '0;
      bus.rvfi_mem_rdata <= '0;
      count_reg          <= ORDER_INIT;
      intr_pending_reg   <= 1'b0;
    end else begin
      bus.rvfi_valid <= emit;
      if (emit) begin
        bus.rvfi_order     <= count_reg;
        bus.rvfi_insn      <= src_insn;
        bus.rvfi_trap      <= emit_trap;
        bus.rvfi_intr      <= intr_pending_reg;
        bus.rvfi_pc        <= src_pc;
        bus.rvfi_rs_addr   <= src_rs_addr;
        bus.rvfi_rs_rdata  <= src_rs_rdata;
        bus.rvfi_rd_addr   <= emit_rd_addr;
        bus.rvfi_rd_wide   <= src_rd_wide;
        bus.rvfi_rd_wdata  <= emit_rd_wdata;
        bus.rvfi_mem_addr  <= src_mem_addr;
        bus.rvfi_mem_mask  <= emit_mem_mask;
        bus.rvfi_mem_wdata <= src_mem_wdata;
        bus.rvfi_mem_rdata <= emit_mem_rdata;
        count_reg          <= count_reg + 64'd1;
        intr_pending_reg   <= emit_trap;
      end
    end
  end
endmodule

// File: tb/tb_frv_rvfi_emitter.sv
// Bench for frv_rvfi_emitter: table vectors, load/reset sequences and random
// traffic checked against a queue-based trace model.
module tb_frv_rvfi_emitter;
  localparam int          XLEN      = 32;
  localparam logic [63:0] WRAP_INIT = 64'hFFFF_FFFF_FFFF_FFFD;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [14:0] rs_addr;
    logic [95:0] rs_rdata;
    logic [4:0]  rd_addr;
    logic        rd_wide;
    logic [63:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_mask;
    logic [31:0] mem_wdata;
  } ret_t;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        intr;
    logic [63:0] pc;
    logic [14:0] rs_addr;
    logic [95:0] rs_rdata;
    logic [4:0]  rd_addr;
    logic        rd_wide;
    logic [63:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
  } trace_t;

  typedef struct {
    ret_t        r;
    logic [4:0]  e_rd_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_mask;
    logic        e_trap;
    logic        e_intr;
  } vec_t;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  frv_rvfi_emitter_if #(.XLEN(XLEN)) bus ();
  frv_rvfi_emitter_if #(.XLEN(XLEN)) bus_w ();

  frv_rvfi_emitter #(.XLEN(XLEN)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .bus(bus)
  );
  // Second copy with the order counter starting just below the wrap point.
  frv_rvfi_emitter #(.XLEN(XLEN), .ORDER_INIT(WRAP_INIT)) dut_w (
    .g_clk(g_clk), .g_resetn(g_resetn), .bus(bus_w)
  );

  assign bus_w.ret_valid     = bus.ret_valid;
  assign bus_w.ret_pc        = bus.ret_pc;
  assign bus_w.ret_insn      = bus.ret_insn;
  assign bus_w.ret_trap      = bus.ret_trap;
  assign bus_w.ret_rs_addr   = bus.ret_rs_addr;
  assign bus_w.ret_rs_rdata  = bus.ret_rs_rdata;
  assign bus_w.ret_rd_addr   = bus.ret_rd_addr;
  assign bus_w.ret_rd_wide   = bus.ret_rd_wide;
  assign bus_w.ret_rd_wdata  = bus.ret_rd_wdata;
  assign bus_w.ret_mem_addr  = bus.ret_mem_addr;
  assign bus_w.ret_mem_mask  = bus.ret_mem_mask;
  assign bus_w.ret_mem_wdata = bus.ret_mem_wdata;
  assign bus_w.mem_rsp_valid = bus.mem_rsp_valid;
  assign bus_w.mem_rsp_rdata = bus.mem_rsp_rdata;
  assign bus_w.mem_rsp_error = bus.mem_rsp_error;

  trace_t got;
  assign got = {bus.rvfi_order, bus.rvfi_insn, bus.rvfi_trap, bus.rvfi_intr,
                bus.rvfi_pc, bus.rvfi_rs_addr, bus.rvfi_rs_rdata,
                bus.rvfi_rd_addr, bus.rvfi_rd_wide, bus.rvfi_rd_wdata,
                bus.rvfi_mem_addr, bus.rvfi_mem_mask, bus.rvfi_mem_wdata,
                bus.rvfi_mem_rdata};

  int          total = 0;
  int          bad = 0;
  int          emit_cnt = 0;
  logic [63:0] m_order = 64'd0;
  logic        m_intr = 1'b0;
  trace_t      expq[$];
  trace_t      exp_rec;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  // Expected trace record from the architectural rules; emission order equals
  // acceptance order, so order/intr can be assigned at submission time.
  function automatic trace_t predict(input ret_t r, input logic [31:0] d, input logic e);
    trace_t t;
    logic   load, trapped;
    logic [31:0] lo, hi;
    load    = (r.mem_mask[3:0] != 4'd0) && !r.trap;
    trapped = r.trap || (load && e);
    lo      = load ? d : r.rd_wdata[31:0];
    hi      = r.rd_wide ? r.rd_wdata[63:32] : 32'd0;
    t.order     = m_order;
    t.insn      = r.insn;
    t.trap      = trapped;
    t.intr      = m_intr;
    t.pc        = r.pc;
    t.rs_addr   = r.rs_addr;
    t.rs_rdata  = r.rs_rdata;
    t.rd_addr   = trapped ? 5'd0 : r.rd_addr;
    t.rd_wide   = r.rd_wide;
    t.rd_wdata  = (t.rd_addr == 5'd0) ? 64'd0 : {hi, lo};
    t.mem_addr  = r.mem_addr;
    t.mem_mask  = trapped ? 8'd0 : r.mem_mask;
    t.mem_wdata = r.mem_wdata;
    t.mem_rdata = load ? d : 32'd0;
    m_order = m_order + 64'd1;
    m_intr  = trapped;
    return t;
  endfunction

  function automatic ret_t mk(input logic [31:0] pc, input logic [31:0] insn,
                              input logic trap, input logic [4:0] rd,
                              input logic wide, input logic [63:0] wdata,
                              input logic [31:0] maddr, input logic [7:0] mask);
    ret_t r;
    r.pc        = {pc + 32'd4, pc};
    r.insn      = insn;
    r.trap      = trap;
    r.rs_addr   = {5'd0, insn[24:20], insn[19:15]};
    r.rs_rdata  = {32'h0, 32'h2222_0002, 32'h1111_0001};
    r.rd_addr   = rd;
    r.rd_wide   = wide;
    r.rd_wdata  = wdata;
    r.mem_addr  = maddr;
    r.mem_mask  = mask;
    r.mem_wdata = 32'h5A5A_0000 ^ pc;
    return r;
  endfunction

  function automatic ret_t rand_rec();
    ret_t r;
    int   kind;
    r.pc        = {$urandom(), $urandom()};
    r.insn      = $urandom();
    r.trap      = ($urandom_range(0, 7) == 0);
    r.rs_addr   = 15'($urandom());
    r.rs_rdata  = {$urandom(), $urandom(), $urandom()};
    r.rd_addr   = 5'($urandom());
    r.rd_wide   = 1'($urandom());
    r.rd_wdata  = {$urandom(), $urandom()};
    r.mem_addr  = $urandom();
    r.mem_wdata = $urandom();
    kind = $urandom_range(0, 2);
    case (kind)
      0:       r.mem_mask = 8'h00;
      1:       r.mem_mask = {4'($urandom_range(1, 15)), 4'h0};
      default: r.mem_mask = {4'h0, 4'($urandom_range(1, 15))};
    endcase
    return r;
  endfunction

  task automatic set_fields(input ret_t r);
    bus.ret_pc        = r.pc;
    bus.ret_insn      = r.insn;
    bus.ret_trap      = r.trap;
    bus.ret_rs_addr   = r.rs_addr;
    bus.ret_rs_rdata  = r.rs_rdata;
    bus.ret_rd_addr   = r.rd_addr;
    bus.ret_rd_wide   = r.rd_wide;
    bus.ret_rd_wdata  = r.rd_wdata;
    bus.ret_mem_addr  = r.mem_addr;
    bus.ret_mem_mask  = r.mem_mask;
    bus.ret_mem_wdata = r.mem_wdata;
  endtask

  task automatic idle(input int n, input logic noise);
    repeat (n) begin
      @(negedge g_clk);
      bus.ret_valid     = 1'b0;
      bus.mem_rsp_valid = noise ? 1'($urandom()) : 1'b0;
      bus.mem_rsp_error = 1'($urandom());
      bus.mem_rsp_rdata = $urandom();
    end
  endtask

  // Presents one record; for loads, answers after 'delay' wait cycles.
  // Returns just after the clock edge that registers the emit.
  task automatic send(input ret_t r, input int delay, input logic [31:0] d, input logic e);
    logic load;
    load = (r.mem_mask[3:0] != 4'd0) && !r.trap;
    @(negedge g_clk);
    chk("ready_idle", 64'(bus.ret_ready), 64'd1);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_error = 1'b0;
    set_fields(r);
    bus.ret_valid = 1'b1;
    expq.push_back(predict(r, d, e));
    @(posedge g_clk);
    if (load) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge g_clk);
        chk("ready_wait", 64'(bus.ret_ready), 64'd0);
        bus.ret_valid     = 1'($urandom());
        bus.mem_rsp_valid = (i == delay - 1);
        bus.mem_rsp_error = (i == delay - 1) ? e : 1'b0;
        bus.mem_rsp_rdata = (i == delay - 1) ? d : $urandom();
      end
      @(posedge g_clk);
    end
  endtask

  initial begin
    ret_t ld, ld2, tmp;
    int   base;

    bus.ret_valid = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_error = 1'b0;
    bus.mem_rsp_rdata = '0;
    set_fields('0);

    vecs[0] = '{mk(32'h100, 32'h0020_81B3, 1'b0, 5'd3, 1'b0, {32'hAAAA_0000, 32'h3}, 32'h0, 8'h00),
                5'd3, 64'h3, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{mk(32'h104, 32'h0E62_A2AB, 1'b0, 5'd5, 1'b1, {32'hDEAD_BEEF, 32'h1234_5678}, 32'h0, 8'h00),
                5'd5, {32'hDEAD_BEEF, 32'h1234_5678}, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{mk(32'h108, 32'h0E62_A02B, 1'b0, 5'd0, 1'b1, {32'hDEAD_BEEF, 32'h1234_5678}, 32'h0, 8'h00),
                5'd0, 64'h0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{mk(32'h10C, 32'h0000_0073, 1'b1, 5'd7, 1'b0, {32'h0, 32'h77}, 32'h3000, 8'h0F),
                5'd0, 64'h0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{mk(32'h200, 32'h0010_0493, 1'b0, 5'd9, 1'b0, {32'h1234, 32'h1}, 32'h0, 8'h00),
                5'd9, 64'h1, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{mk(32'h204, 32'h0020_81B3, 1'b0, 5'd3, 1'b0, {32'h0, 32'h5}, 32'h0, 8'h00),
                5'd3, 64'h5, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{mk(32'h208, 32'h0020_A023, 1'b0, 5'd0, 1'b0, 64'h0, 32'h2000, 8'hF0),
                5'd0, 64'h0, 8'hF0, 1'b0, 1'b0};

    fork
      forever begin
        @(negedge g_clk);
        if (g_resetn && bus.rvfi_valid) begin
          emit_cnt++;
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL trace_spurious got_order=%0d want=no_emit", bus.rvfi_order);
          end else begin
            exp_rec = expq.pop_front();
            if (got !== exp_rec) begin
              bad++;
              $display("FAIL trace got=%h want=%h", got, exp_rec);
            end
          end
          chk("wrap_copy_order", bus_w.rvfi_order, bus.rvfi_order + WRAP_INIT);
        end
      end
    join_none

    repeat (3) @(negedge g_clk);
    chk("reset_valid", 64'(bus.rvfi_valid), 64'd0);
    chk("reset_order", bus.rvfi_order, 64'd0);
    chk("reset_ready", 64'(bus.ret_ready), 64'd1);
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", got);
    end
    g_resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].r, 1, 32'd0, 1'b0);
      @(negedge g_clk);
      #1;
      chk("vec_valid", 64'(bus.rvfi_valid), 64'd1);
      chk("vec_order", bus.rvfi_order, 64'(i));
      chk("vec_rd_addr", 64'(bus.rvfi_rd_addr), 64'(vecs[i].e_rd_addr));
      chk("vec_rd_wdata", bus.rvfi_rd_wdata, vecs[i].e_wdata);
      chk("vec_mem_mask", 64'(bus.rvfi_mem_mask), 64'(vecs[i].e_mask));
      chk("vec_trap", 64'(bus.rvfi_trap), 64'(vecs[i].e_trap));
      chk("vec_intr", 64'(bus.rvfi_intr), 64'(vecs[i].e_intr));
      chk("vec_wrap_order", bus_w.rvfi_order, WRAP_INIT + 64'(i));
      bus.ret_valid = 1'b0;
    end

    ld = mk(32'h300, 32'h0000_A503, 1'b0, 5'd10, 1'b0, {32'h0, 32'h0000_FFFF}, 32'h2000, 8'h0F);
    send(ld, 3, 32'hCAFE_F00D, 1'b0);
    @(negedge g_clk);
    #1;
    chk("load_valid", 64'(bus.rvfi_valid), 64'd1);
    chk("load_mem_rdata", 64'(bus.rvfi_mem_rdata), 64'hCAFE_F00D);
    chk("load_rd_wdata", bus.rvfi_rd_wdata, 64'hCAFE_F00D);
    chk("load_ready_after", 64'(bus.ret_ready), 64'd1);
    bus.ret_valid = 1'b0;

    ld = mk(32'h304, 32'h0000_A583, 1'b0, 5'd11, 1'b0, 64'h0, 32'h2004, 8'h0F);
    send(ld, 2, 32'hBAD0_BAD0, 1'b1);
    @(negedge g_clk);
    #1;
    chk("err_trap", 64'(bus.rvfi_trap), 64'd1);
    chk("err_rd_addr", 64'(bus.rvfi_rd_addr), 64'd0);
    chk("err_rd_wdata", bus.rvfi_rd_wdata, 64'd0);
    chk("err_mem_mask", 64'(bus.rvfi_mem_mask), 64'd0);
    bus.ret_valid = 1'b0;
    send(mk(32'h80, 32'h0010_0493, 1'b0, 5'd9, 1'b0, 64'h1, 32'h0, 8'h00), 1, 32'd0, 1'b0);
    @(negedge g_clk);
    #1;
    chk("intr_after_err", 64'(bus.rvfi_intr), 64'd1);
    bus.ret_valid = 1'b0;
    send(mk(32'h84, 32'h0010_0493, 1'b0, 5'd9, 1'b0, 64'h2, 32'h0, 8'h00), 1, 32'd0, 1'b0);
    @(negedge g_clk);
    #1;
    chk("intr_cleared", 64'(bus.rvfi_intr), 64'd0);
    bus.ret_valid = 1'b0;

    for (int k = 0; k < 300; k++) begin
      tmp = rand_rec();
      send(tmp, $urandom_range(1, 4), $urandom(), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'b1);
    end
    idle(3, 1'b1);

    // Reset while a load waits for its data: the record must vanish.
    ld2 = mk(32'h400, 32'h0000_A603, 1'b0, 5'd12, 1'b0, 64'h0, 32'h2008, 8'h0F);
    @(negedge g_clk);
    bus.mem_rsp_valid = 1'b0;
    set_fields(ld2);
    bus.ret_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    bus.ret_valid = 1'b0;
    chk("rst_wait_ready", 64'(bus.ret_ready), 64'd0);
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_async_valid", 64'(bus.rvfi_valid), 64'd0);
    chk("rst_async_ready", 64'(bus.ret_ready), 64'd1);
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL rst_async_outputs got=%h want=0", got);
    end
    @(negedge g_clk);
    g_resetn = 1'b1;
    m_order = 64'd0;
    m_intr = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_error = 1'b0;
    bus.mem_rsp_rdata = 32'h1357_9BDF;
    @(negedge g_clk);
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("rst_stale_rsp_valid", 64'(bus.rvfi_valid), 64'd0);
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL rst_stale_outputs got=%h want=0", got);
    end
    idle(2, 1'b0);

    base = emit_cnt;
    for (int k = 0; k < 5; k++)
      send(mk(32'h500 + 32'(4 * k), 32'h0020_81B3, 1'b0, 5'd3, 1'b0, 64'(k), 32'h0, 8'h00),
           1, 32'd0, 1'b0);
    @(negedge g_clk);
    #1;
    chk("b2b_count", 64'(emit_cnt - base), 64'd5);
    chk("b2b_last_order", bus.rvfi_order, 64'd4);
    bus.ret_valid = 1'b0;

    idle(3, 1'b0);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frv_rvfi_emitter.md
Name: frv_rvfi_emitter

Overview:
- Producer side of the RVFI retirement trace consumed by the per-instruction formal spec models, including wide (64-bit, rd_wdatahi) masked-instruction writebacks.
- Sits after writeback: accepts one retirement record per handshake, waits for load data where needed, and drives registered rvfi_* outputs with a monotonic order counter.

Parameters:
XLEN, 32, data/address width.

Ports:
g_clk  in  1  clock
g_resetn  in  1  asynchronous active-low reset
ret_valid  in  1  retirement record valid
ret_ready  out  1  emitter can accept a record
ret_pc  in  2*XLEN  {pc_wdata, pc_rdata}
ret_insn  in  32  instruction word
ret_trap  in  1  instruction trapped
ret_rs_addr  in  15  {rs3, rs2, rs1} addresses
ret_rs_rdata  in  3*XLEN  {rs3, rs2, rs1} read data
ret_rd_addr  in  5  destination register
ret_rd_wide  in  1  write is 2*XLEN wide
ret_rd_wdata  in  2*XLEN  {hi, lo} write data; lo ignored for loads
ret_mem_addr  in  XLEN  memory address
ret_mem_mask  in  8  {wmask, rmask}
ret_mem_wdata  in  XLEN  store data
mem_rsp_valid  in  1  load data returned
mem_rsp_rdata  in  XLEN  load data
mem_rsp_error  in  1  load bus error
rvfi_valid  out  1  trace record valid, one cycle
rvfi_order  out  64  retirement index
rvfi_insn  out  32  instruction
rvfi_trap  out  1  trap flag
rvfi_intr  out  1  first instruction of a trap handler
rvfi_pc  out  2*XLEN  {pc_wdata, pc_rdata}
rvfi_rs_addr  out  15  {rs3, rs2, rs1}
rvfi_rs_rdata  out  3*XLEN  {rs3, rs2, rs1}
rvfi_rd_addr  out  5  destination
rvfi_rd_wide  out  1  wide write
rvfi_rd_wdata  out  2*XLEN  {hi, lo}
rvfi_mem_addr  out  XLEN  address
rvfi_mem_mask  out  8  {wmask, rmask}
rvfi_mem_wdata  out  XLEN  store data
rvfi_mem_rdata  out  XLEN  load data

Behaviour:
- **Reset** (async, g_resetn low): every rvfi_* output is 0, order counter is 0, intr_pending is 0, FSM is IDLE. Reset mid-WAIT_MEM discards the held record; no rvfi_valid is produced for it.
- **FSM IDLE:**
  - ret_ready=1. A record is accepted on ret_valid&&ret_ready.
  - Non-load record (rmask==0, or ret_trap=1): rvfi_* registered the next cycle with rvfi_valid=1 for exactly one cycle. Latency is 1.
  - Load record (rmask!=0, ret_trap=0): record captured, move to WAIT_MEM.
- **FSM WAIT_MEM:**
  - ret_ready=0.
  - On mem_rsp_valid: emit next cycle with rvfi_mem_rdata=mem_rsp_rdata and rd lo=mem_rsp_rdata, then return to IDLE.
  - If mem_rsp_error=1: emit rvfi_trap=1, rd_addr=0, rd_wdata=0, mem_mask=0.
  - mem_rsp_valid in IDLE is ignored.
- **rd zeroing:** if rd_addr==0, rvfi_rd_wdata={0,0}. If rd_wide==0, rvfi_rd_wdata hi=0.
- **Trapped record:** rvfi_rd_addr=0, rvfi_mem_mask=0.
- **Order counter:**
  - rvfi_order = count of previously emitted records; increments after each emit.
  - Wraps 2^64-1 -> 0.
- **Interrupt flag:**
  - Each emit with rvfi_trap=1 sets intr_pending.
  - The next emitted record carries rvfi_intr=1 and clears intr_pending.
  - A trap on that record re-sets intr_pending.
- **Back-to-back:** a non-load accept in consecutive IDLE cycles emits every cycle.
- **Load issue rate:** one load outstanding at most; a following record is accepted the cycle the emit is registered.

Test Plan:
- Reset, then add x1,x2,x3 at pc=0x100 -> rvfi_valid for 1 cycle, order=0, pc={0x104,0x100}, rd_addr=3.
- Wide masked op with rd=5, wdata={0xDEADBEEF,0x12345678}, rd_wide=1 -> rvfi_rd_wdata equal to the input. Same op with rd=0 -> rvfi_rd_wdata={0,0}.
- Load at 0x2000, rmask=0xF, mem_rsp after 3 cycles with 0xCAFEF00D -> ret_ready=0 for 3 cycles; emit with mem_rdata=0xCAFEF00D, rd lo=0xCAFEF00D.
- Load with mem_rsp_error=1 -> rvfi_trap=1, rd_addr=0, mem_mask=0. Next record has rvfi_intr=1; the record after has rvfi_intr=0.
- 5 back-to-back ALU records -> 5 consecutive rvfi_valid cycles, order 0..4. Order preset near 2^64-1 -> wraps to 0.
- g_resetn low during WAIT_MEM, then mem_rsp_valid -> no rvfi_valid; outputs 0; next record has order=0.
